// File: rtl/hs32_div_pkg.sv
// rtl/hs32_div_pkg.sv - shared ALU ops constants for the divider (states, flag bits, div-by-zero quotient)
package hs32_div_pkg;

  typedef logic [1:0] div_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int FL_N = 3;
  localparam int FL_Z = 2;
  localparam int FL_C = 1;
  localparam int FL_V = 0;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

  function automatic logic [3:0] mk_flags(input logic [31:0] q, input logic c, input logic v);
    logic [3:0] f;
    f       = 4'b0000;
    f[FL_N] = q[31];
    f[FL_Z] = (q == 32'd0);
    f[FL_C] = c;
    f[FL_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/hs32_div_step.sv
// rtl/hs32_div_step.sv - one combinational restoring shift-subtract step
module hs32_div_step
  import hs32_div_pkg::*;
(
  input  logic [31:0] rem,
  input  logic        a_bit,
  input  logic [31:0] div,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] trial;

  // 33-bit trial: the shifted remainder can exceed 32 bits when the divisor is >= 2^31
  always_comb begin
    shifted  = {rem, a_bit};
    trial    = shifted - {1'b0, div};
    q_bit    = ~trial[32];
    rem_next = q_bit ? trial[31:0] : shifted[31:0];
  end

endmodule

// File: rtl/hs32_div.sv
// rtl/hs32_div.sv - 32-bit iterative divider; signed support with HS32_DIV_SIGNED_EN
module hs32_div
  import hs32_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_q,
  output logic [31:0] o_r,
  output logic [3:0]  o_fl,
  output logic        o_valid,
  input  logic        i_ready
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] a_sh;
  logic [31:0] b_hold;
  logic [31:0] rem;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic        dz;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] rem_nx;
  logic        q_bit;
  logic [31:0] q_step;
  logic        v_flag;

`ifdef HS32_DIV_SIGNED_EN
  logic sgn;
  logic neg_q;
  logic neg_r;
  logic ovf;

  // 0x80000000 negates to itself, which is exactly its unsigned 2^31 magnitude
  assign a_mag  = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign b_mag  = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;
  assign v_flag = ovf;
`else
  logic unused_signed;
  assign unused_signed = i_signed;
  assign a_mag         = i_a;
  assign b_mag         = i_b;
  assign v_flag        = 1'b0;
`endif

  hs32_div_step u_step (
    .rem      (rem),
    .a_bit    (a_sh[31]),
    .div      (b_hold),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  // dividend shifts out the top while quotient bits shift in at the bottom
  assign q_step = {a_sh[30:0], q_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      a_sh   <= 32'd0;
      b_hold <= 32'd0;
      rem    <= 32'd0;
      q_res  <= 32'd0;
      r_res  <= 32'd0;
      dz     <= 1'b0;
`ifdef HS32_DIV_SIGNED_EN
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            cnt    <= 5'd0;
            rem    <= 32'd0;
            a_sh   <= a_mag;
            b_hold <= b_mag;
`ifdef HS32_DIV_SIGNED_EN
            sgn    <= i_signed;
            neg_q  <= i_signed && (i_a[31] ^ i_b[31]);
            neg_r  <= i_signed && i_a[31];
            ovf    <= i_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
`endif
            if (i_b == 32'd0) begin
              dz    <= 1'b1;
              q_res <= DIV0_Q;
              r_res <= i_a;
              state <= ST_DONE;
            end else begin
              dz    <= 1'b0;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          a_sh <= q_step;
          rem  <= rem_nx;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            q_res <= q_step;
            r_res <= rem_nx;
            state <= ST_DONE;
`ifdef HS32_DIV_SIGNED_EN
            if (sgn) state <= ST_FIX;
`endif
          end
        end
`ifdef HS32_DIV_SIGNED_EN
        ST_FIX: begin
          q_res <= neg_q ? (~a_sh + 32'd1) : a_sh;
          r_res <= neg_r ? (~rem + 32'd1) : rem;
          state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (i_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);
  assign o_q     = q_res;
  assign o_r     = r_res;
  assign o_fl    = (state == ST_DONE) ? mk_flags(q_res, dz, v_flag) : 4'b0000;

endmodule

// File: tb/tb_hs32_div.sv
// tb/tb_hs32_div.sv - scoreboard bench for hs32_div (signed cases with HS32_DIV_SIGNED_EN)
module tb_hs32_div;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic        i_signed = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_q;
  logic [31:0] o_r;
  logic [3:0]  o_fl;
  logic        o_valid;
  logic        i_ready = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  hs32_div dut (
    .clk      (clk),
    .reset    (reset),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_signed (i_signed),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_q      (o_q),
    .o_r      (o_r),
    .o_fl     (o_fl),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic sg;
    logic v;
    int   sa;
    int   sb;
`ifdef HS32_DIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
    if (s) sg = 1'b0;
`endif
    v = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 34; v = 1'b1;
    end else if (sg) begin
      sa = a; sb = b;
      e.q = sa / sb; e.r = sa % sb; e.lat = 34;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = 33;
    end
    e.fl = {e.q[31], e.q == 32'd0, b == 32'd0, v};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    exp_t e;
    int   cyc;
    logic [31:0] q0;
    logic [31:0] r0;
    n_chk++;
    if (o_ready !== 1'b1) $display("FAIL idle_ready a=%h b=%h got %b want 1", a, b, o_ready);
    else n_pass++;
    i_a = a; i_b = b; i_signed = s; i_valid = 1'b1;
    exp_q.push_back(model(a, b, s));
    tick();
    i_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    e = exp_q.pop_front();
    n_chk++;
    if (cyc !== e.lat) $display("FAIL latency a=%h b=%h got %0d want %0d", a, b, cyc, e.lat);
    else n_pass++;
    n_chk++;
    if (o_q !== e.q) $display("FAIL quotient a=%h b=%h got %h want %h", a, b, o_q, e.q);
    else n_pass++;
    n_chk++;
    if (o_r !== e.r) $display("FAIL remainder a=%h b=%h got %h want %h", a, b, o_r, e.r);
    else n_pass++;
    n_chk++;
    if (o_fl !== e.fl) $display("FAIL flags a=%h b=%h got %b want %b", a, b, o_fl, e.fl);
    else n_pass++;
    q0 = o_q; r0 = o_r;
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'b1; i_a = $urandom; i_b = $urandom_range(1, 50); i_signed = 1'b0;
      tick();
      n_chk++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_q !== q0 || o_r !== r0)
        $display("FAIL hold_stable cyc=%0d got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=%h r=%h",
                 k, o_valid, o_ready, o_q, o_r, q0, r0);
      else n_pass++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_chk++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_fl !== 4'b0000)
      $display("FAIL release got rdy=%b v=%b fl=%b want rdy=1 v=0 fl=0000", o_ready, o_valid, o_fl);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) $display("FAIL reset_hs got rdy=%b v=%b want 1 0", o_ready, o_valid);
    else n_pass++;
    n_chk++;
    if (o_q !== 32'd0 || o_r !== 32'd0 || o_fl !== 4'd0)
      $display("FAIL reset_data got q=%h r=%h fl=%b want 0 0 0000", o_q, o_r, o_fl);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'd5, 32'd10, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_op($urandom, (i < 3) ? $urandom_range(1, 1000) : $urandom, 1'b0, 0);
  endtask

  task automatic test_div0();
    run_op(32'h1234, 32'd0, 1'b0, 0);
    run_op(32'h8000_0000, 32'd0, 1'b1, 0);
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 0);
    run_op(32'h8000_0000, 32'd3, 1'b1, 0);
  endtask

  task automatic test_mid_reset();
    int cyc;
    i_a = 32'd100; i_b = 32'd7; i_signed = 1'b0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_chk++;
    if (o_ready !== 1'b0) $display("FAIL busy_before_reset got %b want 0", o_ready);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_fl !== 4'd0)
      $display("FAIL mid_reset got rdy=%b v=%b fl=%b want 1 0 0000", o_ready, o_valid, o_fl);
    else n_pass++;
    cyc = 0;
    while (cyc < 40) begin
      n_chk++;
      if (o_valid !== 1'b0) begin
        $display("FAIL discarded_result got o_valid=1 at cyc %0d want 0", cyc);
        cyc = 40;
      end else begin
        n_pass++;
        cyc = cyc + 20;
        for (int k = 0; k < 20; k++) tick();
      end
    end
    run_op(32'd9, 32'd3, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_op(32'd1000, 32'd33, 1'b0, 5);
    run_op(32'd77, 32'd0, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div0();
    test_signed();
    test_mid_reset();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
